// File: rtl/shift_reg_univ_pkg.sv
// Shared constants for the universal shift register: operation modes and FSM states.
// No logic; latency and backpressure are not applicable.
// Imported by shift_reg_univ and shift_reg_univ_step.
package shift_reg_univ_pkg;

  // Operation select driven on the mode input.
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Shift direction as carried between the top level and the step shifter.
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Controller states: IDLE takes per-cycle operations, SHIFT runs a multi-step shift.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // True for the two modes that may launch a multi-step shift.
  function automatic logic is_shift_mode(input logic [1:0] mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL);
  endfunction

endpackage

// File: rtl/shift_reg_univ_step.sv
// One-position shifter: computes the next register value for a single right or left shift.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module shift_reg_univ_step
  import shift_reg_univ_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_dir,
  input  logic             i_sin,
  input  logic             i_rot,
  output logic [WIDTH-1:0] o_q
);

  logic w_fill;

  // Bit entering the vacated end: the outgoing bit when rotating, otherwise the serial input.
  always_comb begin
    w_fill = i_sin;
    if (i_rot) begin
      w_fill = (i_dir == DIR_LEFT) ? i_q[WIDTH-1] : i_q[0];
    end
  end

  // Shift one position toward the LSB (right) or the MSB (left).
  always_comb begin
    o_q = i_q;
    if (i_dir == DIR_LEFT) begin
      o_q = {i_q[WIDTH-2:0], w_fill};
    end else begin
      o_q = {w_fill, i_q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold / shift / load per cycle plus multi-step shift with busy/done.
// Latency: 1 cycle for single ops; amt+1 cycles from start to done for multi-step shifts.
// Backpressure: inputs ignored while busy; a new start is accepted in the done cycle.
// Optional macro SHIFT_REG_UNIV_ROTATE_EN adds input i_rot to turn shifts into rotates.
module shift_reg_univ
  import shift_reg_univ_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_sin_r,
  input  logic             i_sin_l,
  input  logic             i_start,
  input  logic [AMT_W-1:0] i_amt,
`ifdef SHIFT_REG_UNIV_ROTATE_EN
  input  logic             i_rot,
`endif
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_qnot,
  output logic             o_sout_r,
  output logic             o_sout_l,
  output logic             o_busy,
  output logic             o_done
);

  state_t             r_state;
  logic [WIDTH-1:0]   r_q;
  logic [AMT_W-1:0]   r_cnt;
  logic               r_dir;
  logic               r_busy;
  logic               r_done;

  state_t             w_state_nxt;
  logic [WIDTH-1:0]   w_q_nxt;
  logic [AMT_W-1:0]   w_cnt_nxt;
  logic               w_dir_nxt;
  logic               w_done_nxt;

  logic               w_step_dir;
  logic               w_step_sin;
  logic               w_rot;
  logic [WIDTH-1:0]   w_step_q;

`ifdef SHIFT_REG_UNIV_ROTATE_EN
  assign w_rot = i_rot;
`else
  assign w_rot = 1'b0;
`endif

  // A running multi-step shift uses its captured direction; in IDLE the mode decides.
  always_comb begin
    w_step_dir = (i_mode == MODE_SHL) ? DIR_LEFT : DIR_RIGHT;
    if (r_state == ST_SHIFT) begin
      w_step_dir = r_dir;
    end
    w_step_sin = (w_step_dir == DIR_LEFT) ? i_sin_l : i_sin_r;
  end

  // Single shared one-position shifter for both single-step and multi-step paths.
  shift_reg_univ_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_q   (r_q),
    .i_dir (w_step_dir),
    .i_sin (w_step_sin),
    .i_rot (w_rot),
    .o_q   (w_step_q)
  );

  // Next-state and next-register logic for the IDLE/SHIFT controller.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_en) begin
          if (i_start && is_shift_mode(i_mode)) begin
            // Launch edge only captures direction and count; q is untouched.
            w_dir_nxt = (i_mode == MODE_SHL) ? DIR_LEFT : DIR_RIGHT;
            w_cnt_nxt = i_amt;
            if (i_amt == '0) begin
              w_done_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_SHIFT;
            end
          end else begin
            case (i_mode)
              MODE_SHR,
              MODE_SHL:  w_q_nxt = w_step_q;
              MODE_LOAD: w_q_nxt = i_d;
              default:   w_q_nxt = r_q;
            endcase
          end
        end
      end

      ST_SHIFT: begin
        w_q_nxt = w_step_q;
        // Count stays at or above 1 in SHIFT, so the decrement never wraps.
        if (r_cnt <= AMT_W'(1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - AMT_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Controller state register; reset aborts any shift in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and handshake registers; busy mirrors the upcoming state so it is registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q    <= '0;
      r_cnt  <= '0;
      r_dir  <= DIR_RIGHT;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_cnt  <= w_cnt_nxt;
      r_dir  <= w_dir_nxt;
      r_busy <= (w_state_nxt == ST_SHIFT);
      r_done <= w_done_nxt;
    end
  end

  assign o_q      = r_q;
  assign o_qnot   = ~r_q;
  assign o_sout_r = r_q[0];
  assign o_sout_l = r_q[WIDTH-1];
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ (WIDTH=8, AMT_W=4): directed cases then random traffic.
// Compares every cycle against an arithmetic model of the register and its handshake.
// Honours SHIFT_REG_UNIV_ROTATE_EN when the design is built with it.
module tb_shift_reg_univ;

  localparam int WIDTH = 8;
  localparam int AMT_W = 4;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_r;
  logic             sin_l;
  logic             start;
  logic [AMT_W-1:0] amt;
  logic             rot;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qnot;
  logic             sout_r;
  logic             sout_l;
  logic             busy;
  logic             done;

  int n_tests;
  int n_fail;

  // Reference model: register value, shifts still owed, direction, done flag.
  int unsigned m_q;
  int          m_rem;
  bit          m_left;
  bit          m_done;

  shift_reg_univ #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_en     (en),
    .i_mode   (mode),
    .i_d      (d),
    .i_sin_r  (sin_r),
    .i_sin_l  (sin_l),
    .i_start  (start),
    .i_amt    (amt),
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    .i_rot    (rot),
`endif
    .o_q      (q),
    .o_qnot   (qnot),
    .o_sout_r (sout_r),
    .o_sout_l (sout_l),
    .o_busy   (busy),
    .o_done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned shift_val(input int unsigned v, input bit left, input bit fill);
    if (left) return ((v * 2) + fill) % (MASK + 1);
    else      return (v / 2) + (fill ? (1 << (WIDTH - 1)) : 0);
  endfunction

  function automatic bit fill_bit(input int unsigned v, input bit left);
    bit use_rot;
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    use_rot = rot;
`else
    use_rot = 1'b0;
`endif
    if (use_rot) return left ? bit'((v >> (WIDTH - 1)) & 1) : bit'(v & 1);
    return left ? sin_l : sin_r;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    int unsigned nq;
    int          nrem;
    bit          ndone;
    nq    = m_q;
    nrem  = m_rem;
    ndone = 1'b0;
    if (m_rem > 0) begin
      nq   = shift_val(m_q, m_left, fill_bit(m_q, m_left));
      nrem = m_rem - 1;
      if (nrem == 0) ndone = 1'b1;
    end else if (en) begin
      if (start && (mode == 2'd1 || mode == 2'd2)) begin
        m_left = (mode == 2'd2);
        if (amt == 0) ndone = 1'b1;
        else          nrem  = int'(amt);
      end else if (mode == 2'd1) begin
        nq = shift_val(m_q, 1'b0, fill_bit(m_q, 1'b0));
      end else if (mode == 2'd2) begin
        nq = shift_val(m_q, 1'b1, fill_bit(m_q, 1'b1));
      end else if (mode == 2'd3) begin
        nq = int'(d);
      end
    end
    m_q    = nq;
    m_rem  = nrem;
    m_done = ndone;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".q"},      32'(q),      m_q);
    check_eq({tag, ".qnot"},   32'(qnot),   (~m_q) & MASK);
    check_eq({tag, ".sout_r"}, 32'(sout_r), m_q & 1);
    check_eq({tag, ".sout_l"}, 32'(sout_l), (m_q >> (WIDTH - 1)) & 1);
    check_eq({tag, ".busy"},   32'(busy),   32'(m_rem > 0));
    check_eq({tag, ".done"},   32'(done),   32'(m_done));
  endtask

  // Called with the clock low: one edge, then compare shortly after it; returns at the next negedge.
  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic apply_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    m_q = 0; m_rem = 0; m_done = 1'b0;
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_idle();
    en = 1'b0; mode = 2'd0; d = '0; sin_r = 1'b0; sin_l = 1'b0;
    start = 1'b0; amt = '0; rot = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_q = 0; m_rem = 0; m_left = 1'b0; m_done = 1'b0;
    rst_n = 1'b1;
    set_idle();

    // 1. Reset
    @(negedge clk);
    apply_reset("reset");

    // 2. Load and single step
    en = 1'b1; mode = 2'd3; d = 8'hA5;
    tick("load");
    check_eq("load_val", 32'(q), 32'h A5);
    mode = 2'd1; sin_r = 1'b1;
    tick("shr1");
    check_eq("shr1_val", 32'(q), 32'h D2);
    check_eq("shr1_sout_r", 32'(sout_r), 32'h0);

    // 3. Multi-step left by 3 with mode churn while busy
    mode = 2'd3; d = 8'hA5; sin_r = 1'b0;
    tick("reload");
    start = 1'b1; mode = 2'd2; amt = 4'd3; sin_l = 1'b0;
    tick("msl_e0");
    check_eq("msl_e0_busy", 32'(busy), 32'h1);
    start = 1'b0; mode = 2'd3; d = 8'hFF;
    tick("msl_e1");
    check_eq("msl_e1_q", 32'(q), 32'h 4A);
    mode = 2'd1;
    tick("msl_e2");
    check_eq("msl_e2_q", 32'(q), 32'h 94);
    mode = 2'd0;
    tick("msl_e3");
    check_eq("msl_e3_q", 32'(q), 32'h 28);
    check_eq("msl_e3_done", 32'(done), 32'h1);
    check_eq("msl_e3_busy", 32'(busy), 32'h0);
    en = 1'b0;
    tick("msl_after");
    check_eq("msl_done_clear", 32'(done), 32'h0);

    // 4. Zero amount
    en = 1'b1; start = 1'b1; mode = 2'd1; amt = 4'd0;
    tick("zero_e0");
    check_eq("zero_done", 32'(done), 32'h1);
    check_eq("zero_busy", 32'(busy), 32'h0);
    check_eq("zero_q", 32'(q), 32'h 28);
    start = 1'b0; en = 1'b0;
    tick("zero_after");

    // 5. Reset mid-shift
    en = 1'b1; mode = 2'd3; d = 8'hFF;
    tick("ff_load");
    start = 1'b1; mode = 2'd1; amt = 4'd6; sin_r = 1'b0;
    tick("rst_e0");
    start = 1'b0; en = 1'b0;
    tick("rst_e1");
    tick("rst_e2");
    check_eq("rst_two_shifts", 32'(q), 32'h 3F);
    apply_reset("rst_mid");
    for (int i = 0; i < 6; i++) tick("rst_idle");

`ifdef SHIFT_REG_UNIV_ROTATE_EN
    // 6. Rotation
    en = 1'b1; mode = 2'd3; d = 8'h81;
    tick("rot_load");
    rot = 1'b1; start = 1'b1; mode = 2'd1; amt = 4'd1;
    tick("rot1_e0");
    start = 1'b0;
    tick("rot1_e1");
    check_eq("rot1_q", 32'(q), 32'h C0);
    mode = 2'd3; d = 8'h81;
    tick("rot_reload");
    start = 1'b1; mode = 2'd1; amt = 4'd8; sin_r = 1'b0;
    tick("rot8_e0");
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick("rot8");
    check_eq("rot8_q", 32'(q), 32'h 81);
    check_eq("rot8_done", 32'(done), 32'h1);
    rot = 1'b0;
`endif

    // Random traffic with back-to-back starts and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      mode  = 2'($urandom);
      d     = 8'($urandom);
      sin_r = 1'($urandom);
      sin_l = 1'($urandom);
      start = ($urandom_range(0, 2) == 0);
      amt   = 4'($urandom_range(0, 15));
`ifdef SHIFT_REG_UNIV_ROTATE_EN
      rot   = 1'($urandom);
`endif
      if ($urandom_range(0, 249) == 0) apply_reset("rnd_rst");
      else                             tick("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

- Parametrised universal shift register: the clocked, multi-bit successor to the level-sensitive D latch.
- Per-cycle operations: hold, single-step shift right/left, parallel load.
- Multi-step shift: a start/busy/done handshake shifts by a programmable amount, one position per cycle.
- Used as the general storage/serialiser element in the exercise datapaths; provides true and complemented outputs like the latch it replaces.

## Interface

Parameters:
- WIDTH, 8, register width in bits (≥2)
- AMT_W, 4, width of the shift-amount input

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  operation enable in IDLE
- mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
- d  in  WIDTH  parallel load data
- sin_r  in  1  serial input; enters the MSB on a right shift
- sin_l  in  1  serial input; enters the LSB on a left shift
- start  in  1  request a multi-step shift (mode 01/10 only)
- amt  in  AMT_W  number of positions for a multi-step shift
- q  out  WIDTH  register contents
- qnot  out  WIDTH  ~q
- sout_r  out  1  q[0]
- sout_l  out  1  q[WIDTH-1]
- busy  out  1  multi-step shift in progress
- done  out  1  one-cycle pulse when a multi-step shift completes

## Operation

States: IDLE, SHIFT.

IDLE, en=0:
- q holds; start is ignored.

IDLE, en=1, start=0 or mode ∈ {00,11}, one action per edge:
- 00: hold.
- 01: q ← {sin_r, q[WIDTH-1:1]}.
- 10: q ← {q[WIDTH-2:0], sin_l}.
- 11: q ← d.

IDLE, en=1, start=1, mode ∈ {01,10}:
- Capture the direction and cnt ← amt; q is not modified on this edge.
- amt=0: stay IDLE; done=1 next cycle; busy stays 0.
- amt>0: go to SHIFT.

SHIFT:
- Each edge performs one shift in the captured direction, sampling sin_r/sin_l live on that edge, then cnt ← cnt−1.
- On the edge where cnt=1: final shift, go to IDLE, done=1 for one cycle.
- en, mode, d, start and amt are ignored.

Width and boundary rules:
- amt ≥ WIDTH is legal: q becomes entirely serial-input bits.
- cnt is AMT_W bits wide and never wraps.

Outputs:
- qnot, sout_r and sout_l are combinational from q.
- q, busy and done are registered.

Reset (asynchronous, any state, including mid-shift):
- q=0, qnot=all ones, sout_r=sout_l=0, busy=0, done=0, cnt=0, state IDLE.
- An aborted multi-step shift produces no done.

## Timing

- Single-step and load: result visible after the sampling edge (latency 1).
- Multi-step: start sampled at edge E0. busy=1 after E0. Shifts occur at E1…E_amt. After E_amt: busy=0, done=1. done clears at E_amt+1.
- Total latency: amt+1 edges.
- A new start is accepted in the cycle where done=1; the state is already IDLE, so back-to-back transfers have no bubble.
- busy and done are never high together.

## Configuration

Macro SHIFT_REG_UNIV_ROTATE_EN:
- Defined: adds input port rot (1 bit). When rot=1, any shift (single or multi-step) rotates:
  - right: q[0] wraps into the MSB;
  - left: q[WIDTH-1] wraps into the LSB;
  - sin_r and sin_l are ignored.
- rot is sampled on every shift edge.
- Not defined: no rot port; shifts always fill from sin_r/sin_l.

## Structure

Package shift_reg_univ_pkg contains:
- mode constants MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD;
- the state encoding ST_IDLE, ST_SHIFT.

Sub-module shift_reg_univ_step:
- Combinational one-position shifter: (q, dir, serial bit, rot) → next q.
- Used by both single-step and multi-step paths.
- The top level holds the FSM, cnt, q register and handshake.

## Test plan

All with WIDTH=8, AMT_W=4.

1. Reset: assert rst_n=0 mid-cycle → q=0x00, qnot=0xFF, busy=0, done=0 immediately (asynchronous).
2. Load and single step: mode=11, d=0xA5, en=1 → q=0xA5; then mode=01, sin_r=1 → q=0xD2, sout_r=0.
3. Multi-step left: q=0xA5, start, mode=10, amt=3, sin_l=0.
   - busy high for 3 cycles; q=0x4A, 0x94, 0x28 after successive edges.
   - done pulses once as busy falls.
   - Mode changes during busy have no effect.
4. Zero amount: start, mode=01, amt=0 → done=1 for one cycle, busy never high, q unchanged.
5. Reset mid-shift: start, amt=6, from q=0xFF; assert rst_n=0 after 2 shifts → q=0x00, IDLE, no done pulse after release.
6. (SHIFT_REG_UNIV_ROTATE_EN) q=0x81, rot=1, start, mode=01, amt=1 → q=0xC0; amt=8 from 0x81 → q=0x81 at done.
